// File: rtl/rom_pattern_reader.sv
// Pattern ROM consumer: fetches three phase words, serialises them LSB first at a
// programmable sample rate, and drives complementary gate pairs with dead-time insertion.
module rom_pattern_reader #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned DT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DIV_W-1:0]  div,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic [DT_W-1:0]   dead_time,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_out1,
   input  logic [DATA_W-1:0] rom_out2,
   input  logic [DATA_W-1:0] rom_out3,
   output logic [2:0]        gate_h,
   output logic [2:0]        gate_l,
   output logic              sample_tick,
   output logic              period_start
);

   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned NPH   = 3;

   typedef enum logic [2:0] {IDLE, FILL0, FILL1, FILL2, RUN} state_t;

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            last_q, last_d;
   logic [ADDR_W-1:0]            waddr_q, waddr_d;
   logic [BIT_W-1:0]             bit_q, bit_d;
   logic [DIV_W-1:0]             cnt_q, cnt_d;
   logic [NPH-1:0][DATA_W-1:0]   shadow_q, shadow_d;
   logic [NPH-1:0][DATA_W-1:0]   pref_q, pref_d;
   logic [NPH-1:0]               ps_q, ps_d;
   logic [NPH-1:0]               tgt_q, tgt_d;
   logic [NPH-1:0][DT_W-1:0]     dt_q, dt_d;
   logic                         pend_q, pend_d;
   logic                         cap_q, cap_d;
   logic                         rom_en_d;
   logic [ADDR_W-1:0]            rom_addr_d;
   logic [2:0]                   gate_h_d, gate_l_d;
   logic                         tick_d, pstart_d;
   logic                         abort_c;
   logic [NPH-1:0][DATA_W-1:0]   rom_data;

   assign rom_data = {rom_out3, rom_out2, rom_out1};
   assign abort_c  = (state_q != IDLE) && !enable;

   function automatic logic [ADDR_W-1:0] nxt_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] last);
      return (a == last) ? '0 : ADDR_W'(a + ADDR_W'(1));
   endfunction

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      waddr_d    = waddr_q;
      bit_d      = bit_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      pref_d     = pref_q;
      ps_d       = ps_q;
      tgt_d      = tgt_q;
      dt_d       = dt_q;
      pend_d     = 1'b0;
      cap_d      = rom_en;
      rom_en_d   = 1'b0;
      rom_addr_d = rom_addr;
      gate_h_d   = '0;
      gate_l_d   = '0;
      tick_d     = 1'b0;
      pstart_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = FILL0;
               last_d     = last_addr;
               rom_en_d   = 1'b1;
               rom_addr_d = '0;
            end
         end
         FILL0: begin
            state_d    = FILL1;
            rom_en_d   = 1'b1;
            rom_addr_d = nxt_addr('0, last_q);
         end
         FILL1: begin
            state_d  = FILL2;
            shadow_d = rom_data;
         end
         FILL2: begin
            // preload the divider so the first RUN cycle is a tick
            state_d = RUN;
            pref_d  = rom_data;
            cnt_d   = div;
            tick_d  = 1'b1;
         end
         RUN: begin
            if (cap_q) pref_d = rom_data;
            if (sample_tick) begin
               cnt_d = '0;
               for (int unsigned p = 0; p < NPH; p++) ps_d[p] = shadow_q[p][bit_q];
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  shadow_d = pref_q;
                  bit_d    = '0;
                  waddr_d  = nxt_addr(waddr_q, last_q);
                  pend_d   = 1'b1;
               end else begin
                  bit_d = BIT_W'(bit_q + BIT_W'(1));
               end
            end else begin
               cnt_d = DIV_W'(cnt_q + DIV_W'(1));
            end
            if (pend_q) begin
               rom_en_d   = 1'b1;
               rom_addr_d = nxt_addr(waddr_q, last_q);
            end
            tick_d = (cnt_d == div);
         end
         default: state_d = IDLE;
      endcase

      // Dead-time: a phase change drops both gates; the target rises when the count expires
      if (state_q == FILL2 || state_q == RUN) begin
         for (int unsigned p = 0; p < NPH; p++) begin
            if (ps_q[p] != tgt_q[p]) begin
               tgt_d[p] = ps_q[p];
               dt_d[p]  = dead_time;
               if (dead_time == '0) begin
                  gate_h_d[p] = ps_q[p];
                  gate_l_d[p] = ~ps_q[p];
               end
            end else if (dt_q[p] != '0) begin
               dt_d[p] = DT_W'(dt_q[p] - DT_W'(1));
               if (dt_q[p] == DT_W'(1)) begin
                  gate_h_d[p] = tgt_q[p];
                  gate_l_d[p] = ~tgt_q[p];
               end
            end else begin
               gate_h_d[p] = tgt_q[p];
               gate_l_d[p] = ~tgt_q[p];
            end
         end
      end

      pstart_d = tick_d && (bit_d == '0) && (waddr_d == '0);
   end

   // State and output registers; reset and enable drop share the clear path
   always_ff @(posedge clk) begin
      if (!rst_n || abort_c) begin
         state_q      <= IDLE;
         last_q       <= '0;
         waddr_q      <= '0;
         bit_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         pref_q       <= '0;
         ps_q         <= '0;
         tgt_q        <= '0;
         dt_q         <= '0;
         pend_q       <= 1'b0;
         cap_q        <= 1'b0;
         rom_en       <= 1'b0;
         rom_addr     <= '0;
         gate_h       <= '0;
         gate_l       <= '0;
         sample_tick  <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         waddr_q      <= waddr_d;
         bit_q        <= bit_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         pref_q       <= pref_d;
         ps_q         <= ps_d;
         tgt_q        <= tgt_d;
         dt_q         <= dt_d;
         pend_q       <= pend_d;
         cap_q        <= cap_d;
         rom_en       <= rom_en_d;
         rom_addr     <= rom_addr_d;
         gate_h       <= gate_h_d;
         gate_l       <= gate_l_d;
         sample_tick  <= tick_d;
         period_start <= pstart_d;
      end
   end

endmodule

// File: tb/tb_rom_pattern_reader.sv
// Randomised bench for rom_pattern_reader against a cycle-indexed behavioural model.
module tb_rom_pattern_reader;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DIV_W  = 16;
   localparam int unsigned DT_W   = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic [DIV_W-1:0]  div = '0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [DT_W-1:0]   dead_time = '0;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_out1 = '0;
   logic [DATA_W-1:0] rom_out2 = '0;
   logic [DATA_W-1:0] rom_out3 = '0;
   logic [2:0]        gate_h, gate_l;
   logic              sample_tick, period_start;

   logic [15:0] rom_mem [3][16];
   int m_last, m_div, m_dt;
   int checks = 0;
   int errors = 0;

   rom_pattern_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .DT_W(DT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .div(div), .last_addr(last_addr),
      .dead_time(dead_time), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_out1(rom_out1), .rom_out2(rom_out2), .rom_out3(rom_out3),
      .gate_h(gate_h), .gate_l(gate_l), .sample_tick(sample_tick), .period_start(period_start)
   );

   always #5 clk = ~clk;

   // ROM with one-cycle read latency
   always @(posedge clk) begin
      if (rom_en) begin
         rom_out1 <= rom_mem[0][rom_addr[3:0]];
         rom_out2 <= rom_mem[1][rom_addr[3:0]];
         rom_out3 <= rom_mem[2][rom_addr[3:0]];
      end
   end

   // Phase value visible in RUN cycle r: bit of the most recent tick, 0 before any tick
   function automatic logic mps(int p, int r);
      int j;
      logic [15:0] w;
      if (r <= 0) return 1'b0;
      j = (r - 1) / (m_div + 1);
      w = rom_mem[p][(j / 16) % (m_last + 1)];
      return w[j % 16];
   endfunction

   // Expected {rom_en, rom_addr, gate_h, gate_l, sample_tick, period_start}, k cycles after enable edge
   function automatic logic [24:0] exp_vec(int k);
      logic en, tk, pst, chg;
      logic [15:0] a;
      logic [2:0] gh, gl;
      int r, j, lo;
      en = 1'b0; a = '0; gh = '0; gl = '0; tk = 1'b0; pst = 1'b0;
      if (k == 0) begin
         en = 1'b1;
      end else if (k == 1) begin
         en = 1'b1;
         a  = (m_last == 0) ? 16'd0 : 16'd1;
      end else if (k >= 3) begin
         r   = k - 3;
         tk  = (r % (m_div + 1)) == 0;
         pst = tk && (((r / (m_div + 1)) % (16 * (m_last + 1))) == 0);
         if (r >= 2 && ((r - 2) % (m_div + 1)) == 0) begin
            j = (r - 2) / (m_div + 1);
            if (j % 16 == 15) begin
               en = 1'b1;
               a  = 16'((j / 16 + 2) % (m_last + 1));
            end
         end
         lo = (r - m_dt > 1) ? r - m_dt : 1;
         for (int p = 0; p < 3; p++) begin
            chg = 1'b0;
            for (int c = lo; c < r; c++) if (mps(p, c) != mps(p, c - 1)) chg = 1'b1;
            if (!chg) begin
               gh[p] = mps(p, r - 1);
               gl[p] = !mps(p, r - 1);
            end
         end
      end
      return {en, a, gh, gl, tk, pst};
   endfunction

   function automatic logic [24:0] act_vec();
      return {rom_en, rom_en ? rom_addr : 16'h0, gate_h, gate_l, sample_tick, period_start};
   endfunction

   task automatic configure(int last, int dv, int dt);
      m_last = last; m_div = dv; m_dt = dt;
      last_addr = ADDR_W'(last);
      div       = DIV_W'(dv);
      dead_time = DT_W'(dt);
   endtask

   task automatic fill_same(logic [15:0] base, logic use_addr);
      for (int p = 0; p < 3; p++)
         for (int a = 0; a < 16; a++) rom_mem[p][a] = use_addr ? (base ^ 16'(a)) : base;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      rst_n  = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (act_vec() !== 25'h0) begin
            errors++;
            $display("FAIL reset: outputs %h, required 0", act_vec());
         end
      end
      enable = 1'b0;
      rst_n  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (act_vec() !== 25'h0) begin
         errors++;
         $display("FAIL reset_idle: outputs %h, required 0", act_vec());
      end
   endtask

   task automatic test_pattern(string name, int last, int dv, int dt, int n);
      configure(last, dv, dt);
      enable = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         checks++;
         if (act_vec() !== exp_vec(k) || (gate_h & gate_l) !== 3'b000) begin
            errors++;
            $display("FAIL %s k=%0d: got %h, required %h", name, k, act_vec(), exp_vec(k));
         end
      end
      enable = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (act_vec() !== 25'h0) begin
         errors++;
         $display("FAIL %s_stop: outputs %h, required 0", name, act_vec());
      end
   endtask

   task automatic test_disable();
      fill_same(16'hA5A5, 1'b1);
      configure(3, 0, 0);
      enable = 1'b1;
      for (int k = 0; k < 43; k++) begin
         @(posedge clk); #1;
         checks++;
         if (act_vec() !== exp_vec(k)) begin
            errors++;
            $display("FAIL disable_run k=%0d: got %h, required %h", k, act_vec(), exp_vec(k));
         end
      end
      enable = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (act_vec() !== 25'h0) begin
         errors++;
         $display("FAIL disable_drop: outputs %h, required 0", act_vec());
      end
      enable = 1'b1;
      for (int k = 0; k < 90; k++) begin
         @(posedge clk); #1;
         checks++;
         if (act_vec() !== exp_vec(k)) begin
            errors++;
            $display("FAIL disable_restart k=%0d: got %h, required %h", k, act_vec(), exp_vec(k));
         end
      end
      enable = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midrun();
      fill_same(16'h5AC3, 1'b1);
      configure(2, 1, 2);
      enable = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         checks++;
         if (act_vec() !== exp_vec(k)) begin
            errors++;
            $display("FAIL rst_mid_run k=%0d: got %h, required %h", k, act_vec(), exp_vec(k));
         end
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (act_vec() !== 25'h0) begin
         errors++;
         $display("FAIL rst_mid_edge: outputs %h, required 0", act_vec());
      end
      rst_n = 1'b1;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         checks++;
         if (act_vec() !== exp_vec(k)) begin
            errors++;
            $display("FAIL rst_mid_restart k=%0d: got %h, required %h", k, act_vec(), exp_vec(k));
         end
      end
      enable = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random(int iters);
      int last, dv, dt, n;
      for (int it = 0; it < iters; it++) begin
         for (int p = 0; p < 3; p++)
            for (int a = 0; a < 16; a++) rom_mem[p][a] = 16'($urandom);
         last = int'($urandom_range(0, 4));
         dv   = int'($urandom_range(0, 3));
         dt   = int'($urandom_range(0, 6));
         configure(last, dv, dt);
         n = 3 + 16 * (last + 1) * (dv + 1) + 40;
         enable = 1'b1;
         for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            checks++;
            if (act_vec() !== exp_vec(k) || (gate_h & gate_l) !== 3'b000) begin
               errors++;
               $display("FAIL random it=%0d k=%0d: got %h, required %h", it, k, act_vec(), exp_vec(k));
            end
         end
         enable = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (act_vec() !== 25'h0) begin
            errors++;
            $display("FAIL random_stop it=%0d: outputs %h, required 0", it, act_vec());
         end
      end
   endtask

   initial begin
      fill_same(16'hA5A5, 1'b1);
      configure(3, 0, 0);
      @(posedge clk); #1;
      test_reset();
      test_pattern("pattern_div0", 3, 0, 0, 3 + 150);
      test_pattern("divider_div4", 3, 4, 0, 3 + 200);
      fill_same(16'h0001, 1'b0);
      test_pattern("dead_time3", 0, 9, 3, 3 + 200);
      fill_same(16'h0002, 1'b0);
      test_pattern("dead_reload", 0, 0, 10, 3 + 80);
      fill_same(16'hA5A5, 1'b1);
      test_pattern("single_word", 0, 0, 1, 3 + 60);
      test_disable();
      test_reset_midrun();
      test_random(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
